// File: rtl/tc_arith_pkg.sv
// Shared arithmetic helpers for the product accumulator: state encoding,
// default widths, sign extension and per-width saturation limits.
package tc_arith_pkg;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} acc_state_e;

  localparam int PW_DEF = 8;
  localparam int AW_DEF = 16;

  localparam logic [AW_DEF-1:0] MAX_AW = {1'b0, {(AW_DEF-1){1'b1}}};
  localparam logic [AW_DEF-1:0] MIN_AW = {1'b1, {(AW_DEF-1){1'b0}}};

  // Sign-extend the low pw bits of v (upper bits of v must be zero) to 64 bits;
  // callers truncate to their own accumulator width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned pw);
    logic [63:0] m;
    m = 64'd1 << (pw - 1);
    return (v ^ m) - m;
  endfunction

  function automatic logic [63:0] sat_max(input int unsigned aw);
    return (64'd1 << (aw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned aw);
    return 64'd1 << (aw - 1);
  endfunction

endpackage

// File: rtl/tc_sat_add.sv
// AW-bit signed adder with overflow flag; clamps to the signed limits when
// TC_PROD_ACCUM_SAT_EN is defined, otherwise wraps.
module tc_sat_add
  import tc_arith_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_b,
  output logic [AW-1:0] o_sum,
  output logic          o_ovf
);

  logic [AW-1:0] w_raw;

  assign w_raw = i_a + i_b;
  // Operands agree in sign but the raw sum does not.
  assign o_ovf = (i_a[AW-1] == i_b[AW-1]) && (w_raw[AW-1] != i_a[AW-1]);

`ifdef TC_PROD_ACCUM_SAT_EN
  localparam logic [AW-1:0] MAX_S = AW'(sat_max(AW));
  localparam logic [AW-1:0] MIN_S = AW'(sat_min(AW));

  always_comb begin
    o_sum = w_raw;
    if (o_ovf) o_sum = i_a[AW-1] ? MIN_S : MAX_S;
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/tc_prod_accum.sv
// Sums N_TERMS sign-extended products into one result with valid/ready on both
// sides. Optional saturation and ovf port under TC_PROD_ACCUM_SAT_EN.
module tc_prod_accum
  import tc_arith_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int AW      = AW_DEF,
  parameter int N_TERMS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic [PW-1:0] prod,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic [AW-1:0] acc_out,
  output logic          acc_valid,
  input  logic          acc_ready
`ifdef TC_PROD_ACCUM_SAT_EN
  ,
  output logic          ovf
`endif
);

  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  acc_state_e    r_state;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc_out;
  logic          r_acc_valid;

  logic [AW-1:0] w_sext;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_next;
  logic          w_accept;

  assign prod_ready = (r_state == ACCUM) && !clear && reset_n;
  assign w_accept   = prod_valid && prod_ready;
  assign w_sext     = AW'(sext(64'(prod), PW));

`ifdef TC_PROD_ACCUM_SAT_EN
  logic w_add_ovf;
  logic w_next_sat;
  logic r_sat;
  logic r_ovf;

  tc_sat_add #(.AW(AW)) u_add (
    .i_a   (r_acc),
    .i_b   (w_sext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Once clamped, the accumulator stays at the limit until the result is out.
  assign w_next     = r_sat ? r_acc : w_sum;
  assign w_next_sat = r_sat | w_add_ovf;
  assign ovf        = r_ovf;
`else
  logic w_add_ovf_unused;

  tc_sat_add #(.AW(AW)) u_add (
    .i_a   (r_acc),
    .i_b   (w_sext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf_unused)
  );

  assign w_next = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
`ifdef TC_PROD_ACCUM_SAT_EN
      r_sat       <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else if (clear) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_acc_valid <= 1'b0;
`ifdef TC_PROD_ACCUM_SAT_EN
      r_sat       <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ACCUM: if (w_accept) begin
          if (r_cnt == LAST) begin
            r_acc_out   <= w_next;
            r_acc_valid <= 1'b1;
            r_state     <= DONE;
            r_acc       <= '0;
            r_cnt       <= '0;
`ifdef TC_PROD_ACCUM_SAT_EN
            r_ovf       <= w_next_sat;
            r_sat       <= 1'b0;
`endif
          end else begin
            r_acc <= w_next;
            r_cnt <= r_cnt + CW'(1);
`ifdef TC_PROD_ACCUM_SAT_EN
            r_sat <= w_next_sat;
`endif
          end
        end
        DONE: if (acc_ready) begin
          r_acc_valid <= 1'b0;
          r_state     <= ACCUM;
`ifdef TC_PROD_ACCUM_SAT_EN
          r_ovf       <= 1'b0;
`endif
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign acc_out   = r_acc_out;
  assign acc_valid = r_acc_valid;

endmodule

// File: tb/tb_tc_prod_accum.sv
// Directed bench for tc_prod_accum: a 16-bit and an 8-bit accumulator driven by
// the same stimulus; saturation expectations follow TC_PROD_ACCUM_SAT_EN.
module tb_tc_prod_accum;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  prod = '0;
  logic        prod_valid = 1'b0;
  logic        acc_ready = 1'b1;
  logic        prod_ready, prod_ready8;
  logic [15:0] acc_out;
  logic [7:0]  acc_out8;
  logic        acc_valid, acc_valid8;
`ifdef TC_PROD_ACCUM_SAT_EN
  logic        ovf, ovf8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tc_prod_accum #(.PW(8), .AW(16), .N_TERMS(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
`ifdef TC_PROD_ACCUM_SAT_EN
    , .ovf(ovf)
`endif
  );

  tc_prod_accum #(.PW(8), .AW(8), .N_TERMS(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready8), .acc_out(acc_out8),
    .acc_valid(acc_valid8), .acc_ready(acc_ready)
`ifdef TC_PROD_ACCUM_SAT_EN
    , .ovf(ovf8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p);
    prod = p;
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] v4 [4];
    logic       pat [7];
    v4 = '{8'h03, 8'hFE, 8'h40, 8'hC8};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset state
    step(); step();
    chk("rst_valid", 32'(acc_valid), 32'd0);
    chk("rst_out", 32'(acc_out), 32'd0);
    chk("rst_ready_low", 32'(prod_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(prod_ready), 32'd1);

    // basic dot product, consumer always ready
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("no_early_valid", 32'(acc_valid), 32'd0);
      send(v4[i]);
    end
    chk("t1_out", 32'(acc_out), 32'h0009);
    chk("t1_valid", 32'(acc_valid), 32'd1);
    chk("t1_ready_done", 32'(prod_ready), 32'd0);
    step();
    chk("t1_valid_one_cycle", 32'(acc_valid), 32'd0);
    chk("t1_ready_back", 32'(prod_ready), 32'd1);

    // output backpressure for 5 cycles, offered products ignored
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(v4[i]);
    prod = 8'h7F;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_out", 32'(acc_out), 32'h0009);
      chk("t2_hold_valid", 32'(acc_valid), 32'd1);
      chk("t2_backpressure", 32'(prod_ready), 32'd0);
      step();
    end
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    step();
    chk("t2_handoff_valid", 32'(acc_valid), 32'd0);
    chk("t2_handoff_ready", 32'(prod_ready), 32'd1);
    chk("t2_out_kept", 32'(acc_out), 32'h0009);

    // gaps in prod_valid
    prod = 8'h01;
    for (int i = 0; i < 7; i++) begin
      prod_valid = pat[i];
      if (i == 6) chk("t3_not_yet", 32'(acc_valid), 32'd0);
      step();
    end
    prod_valid = 1'b0;
    chk("t3_out", 32'(acc_out), 32'h0004);
    chk("t3_valid", 32'(acc_valid), 32'd1);
    step();

    // clear aborts a partial sum
    send(8'h7F); send(8'h7F);
    clear = 1'b1;
    #1;
    chk("t4_ready_in_clear", 32'(prod_ready), 32'd0);
    step();
    clear = 1'b0;
    chk("t4_no_result", 32'(acc_valid), 32'd0);
    chk("t4_out_holds", 32'(acc_out), 32'h0004);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("t4_not_yet", 32'(acc_valid), 32'd0);
      send(8'h01);
    end
    chk("t4_out", 32'(acc_out), 32'h0004);
    chk("t4_valid", 32'(acc_valid), 32'd1);
    step();

    // overflow on the 8-bit instance
    for (int i = 0; i < 4; i++) send(8'h40);
    chk("t5_pos_out16", 32'(acc_out), 32'h0100);
`ifdef TC_PROD_ACCUM_SAT_EN
    chk("t5_pos_out8", 32'(acc_out8), 32'h7F);
    chk("t5_pos_ovf8", 32'(ovf8), 32'd1);
    chk("t5_pos_ovf16", 32'(ovf), 32'd0);
`else
    chk("t5_pos_out8", 32'(acc_out8), 32'h00);
`endif
    chk("t5_pos_valid8", 32'(acc_valid8), 32'd1);
    step();
    for (int i = 0; i < 4; i++) send(8'hC8);
    chk("t5_neg_out16", 32'(acc_out), 32'hFF20);
`ifdef TC_PROD_ACCUM_SAT_EN
    chk("t5_neg_out8", 32'(acc_out8), 32'h80);
    chk("t5_neg_ovf8", 32'(ovf8), 32'd1);
`else
    chk("t5_neg_out8", 32'(acc_out8), 32'h20);
`endif
    step();

    // reset while a result is pending
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h01);
    chk("t6_pending", 32'(acc_valid), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("t6_valid", 32'(acc_valid), 32'd0);
    chk("t6_out", 32'(acc_out), 32'h0000);
    chk("t6_ready", 32'(prod_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
